data_memory_stage: RTL and testbench

- MEM-stage data memory of the SPARC pipeline.
- Consumes the 5-bit data-memory control bundle and the address/store data produced by the EX/MEM pipeline register.
- Provides a 512x8 big-endian byte-addressed RAM with byte/halfword/word loads and stores, sign/zero extension, and alignment checking.
- Load data is registered and feeds the output-handler mux ahead of MEM/WB.

---
 rtl/data_memory_stage.sv | 158 +++++++++++++++
 tb/tb_data_memory_stage.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/data_memory_stage.sv
// MEM-stage data memory: 512x8 big-endian byte RAM with byte/half/word access,
// sign/zero extension and alignment fault reporting. Optional macro: DATA_MEM_STATS_EN.
module data_memory_stage #(
    parameter int unsigned DEPTH = 512,
    parameter int unsigned AW    = 9
) (
    input  logic          clk,
    input  logic          clr,
    input  logic [4:0]    mem_ctrl,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   data_in,
    output logic [31:0]   data_out,
    output logic          load_valid,
    output logic          misaligned,
    output logic          fault_sticky
`ifdef DATA_MEM_STATS_EN
    ,
    output logic [15:0]   load_count,
    output logic [15:0]   store_count
`endif
);

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_R = 2'b11;

    logic [7:0] mem_q [DEPTH];

    logic          se_c;
    logic          wr_c;
    logic          en_c;
    logic [1:0]    size_c;
    logic          fault_c;
    logic          st_ok_c;
    logic          ld_ok_c;
    logic [AW-1:0] a1_c;
    logic [AW-1:0] a2_c;
    logic [AW-1:0] a3_c;
    logic [7:0]    b0_c;
    logic [7:0]    b1_c;
    logic [7:0]    b2_c;
    logic [7:0]    b3_c;
    logic [31:0]   ld_c;

    logic [31:0] data_q, data_d;
    logic        lv_q, lv_d;
    logic        mis_q, mis_d;
    logic        sticky_q, sticky_d;

    // Control decode and alignment check; accesses during clr are dropped.
    always_comb begin
        se_c    = mem_ctrl[0];
        wr_c    = mem_ctrl[1];
        en_c    = mem_ctrl[2];
        size_c  = mem_ctrl[4:3];
        fault_c = en_c && ((size_c == SIZE_R) ||
                           ((size_c == SIZE_H) && addr[0]) ||
                           ((size_c == SIZE_W) && (addr[1:0] != 2'b00)));
        st_ok_c = en_c && !fault_c && !clr && wr_c;
        ld_ok_c = en_c && !fault_c && !clr && !wr_c;
    end

    // Aligned accesses never cross the top of memory, so no wrap handling.
    assign a1_c = addr + AW'(1);
    assign a2_c = addr + AW'(2);
    assign a3_c = addr + AW'(3);
    assign b0_c = mem_q[addr];
    assign b1_c = mem_q[a1_c];
    assign b2_c = mem_q[a2_c];
    assign b3_c = mem_q[a3_c];

    always_comb begin
        ld_c = {b0_c, b1_c, b2_c, b3_c};
        unique case (size_c)
            SIZE_B:  ld_c = {{24{se_c & b0_c[7]}}, b0_c};
            SIZE_H:  ld_c = {{16{se_c & b0_c[7]}}, b0_c, b1_c};
            default: ld_c = {b0_c, b1_c, b2_c, b3_c};
        endcase
    end

    // Big-endian byte lane writes; uncovered bytes are left alone.
    always_ff @(posedge clk) begin
        if (st_ok_c) begin
            unique case (size_c)
                SIZE_B: mem_q[addr] <= data_in[7:0];
                SIZE_H: begin
                    mem_q[addr] <= data_in[15:8];
                    mem_q[a1_c] <= data_in[7:0];
                end
                SIZE_W: begin
                    mem_q[addr] <= data_in[31:24];
                    mem_q[a1_c] <= data_in[23:16];
                    mem_q[a2_c] <= data_in[15:8];
                    mem_q[a3_c] <= data_in[7:0];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        data_d   = data_q;
        lv_d     = 1'b0;
        mis_d    = fault_c;
        sticky_d = sticky_q | fault_c;
        if (ld_ok_c) begin
            data_d = ld_c;
            lv_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            data_q   <= 32'h0;
            lv_q     <= 1'b0;
            mis_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            data_q   <= data_d;
            lv_q     <= lv_d;
            mis_q    <= mis_d;
            sticky_q <= sticky_d;
        end
    end

    assign data_out     = data_q;
    assign load_valid   = lv_q;
    assign misaligned   = mis_q;
    assign fault_sticky = sticky_q;

`ifdef DATA_MEM_STATS_EN
    logic [15:0] ld_cnt_q, ld_cnt_d;
    logic [15:0] st_cnt_q, st_cnt_d;

    // Saturating counters of completed, non-faulting accesses.
    always_comb begin
        ld_cnt_d = ld_cnt_q;
        st_cnt_d = st_cnt_q;
        if (ld_ok_c && (ld_cnt_q != 16'hFFFF)) ld_cnt_d = ld_cnt_q + 16'(1);
        if (st_ok_c && (st_cnt_q != 16'hFFFF)) st_cnt_d = st_cnt_q + 16'(1);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            ld_cnt_q <= 16'h0;
            st_cnt_q <= 16'h0;
        end else begin
            ld_cnt_q <= ld_cnt_d;
            st_cnt_q <= st_cnt_d;
        end
    end

    assign load_count  = ld_cnt_q;
    assign store_count = st_cnt_q;
`endif

endmodule

// File: tb/tb_data_memory_stage.sv
// Self-checking bench for data_memory_stage: byte-array reference model,
// per-cycle output compare, directed cases plus randomized traffic.
module tb_data_memory_stage;

    logic        clk;
    logic        clr;
    logic [4:0]  mem_ctrl;
    logic [8:0]  addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        load_valid;
    logic        misaligned;
    logic        fault_sticky;
`ifdef DATA_MEM_STATS_EN
    logic [15:0] load_count;
    logic [15:0] store_count;
`endif

    data_memory_stage dut (
        .clk          (clk),
        .clr          (clr),
        .mem_ctrl     (mem_ctrl),
        .addr         (addr),
        .data_in      (data_in),
        .data_out     (data_out),
        .load_valid   (load_valid),
        .misaligned   (misaligned),
        .fault_sticky (fault_sticky)
`ifdef DATA_MEM_STATS_EN
        ,
        .load_count   (load_count),
        .store_count  (store_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: byte array plus expected output values.
    logic [7:0]  mem_m [512];
    logic [31:0] exp_data   = 32'h0;
    logic        exp_lv     = 1'b0;
    logic        exp_mis    = 1'b0;
    logic        exp_sticky = 1'b0;
    int          exp_ldc    = 0;
    int          exp_stc    = 0;
    bit          started    = 1'b0;

    always @(posedge clk) begin
        int sz, nb, a;
        bit en, wr, se, fault;
        logic [31:0] v;
        started = 1'b1;
        sz = int'(mem_ctrl[4:3]);
        en = mem_ctrl[2];
        wr = mem_ctrl[1];
        se = mem_ctrl[0];
        a  = int'(addr);
        nb = 1 << sz;
        fault = en && (sz == 3 || (a % nb) != 0);
        if (clr) begin
            exp_data = 0; exp_lv = 0; exp_mis = 0; exp_sticky = 0;
            exp_ldc = 0; exp_stc = 0;
        end else if (!en) begin
            exp_lv = 0; exp_mis = 0;
        end else if (fault) begin
            exp_lv = 0; exp_mis = 1; exp_sticky = 1;
        end else if (wr) begin
            for (int i = 0; i < nb; i++)
                mem_m[a + i] = 8'(data_in >> (8 * (nb - 1 - i)));
            exp_lv = 0; exp_mis = 0;
            if (exp_stc < 65535) exp_stc++;
        end else begin
            v = 0;
            for (int i = 0; i < nb; i++) v = (v << 8) | 32'(mem_m[a + i]);
            if (se && nb < 4 && v[8 * nb - 1]) v = v | (32'hFFFFFFFF << (8 * nb));
            exp_data = v; exp_lv = 1; exp_mis = 0;
            if (exp_ldc < 65535) exp_ldc++;
        end
    end

    // Every-cycle comparison of registered outputs against the model.
    always @(negedge clk) begin
        if (started) begin
            chk("data_out", data_out, exp_data);
            chk("load_valid", 32'(load_valid), 32'(exp_lv));
            chk("misaligned", 32'(misaligned), 32'(exp_mis));
            chk("fault_sticky", 32'(fault_sticky), 32'(exp_sticky));
`ifdef DATA_MEM_STATS_EN
            chk("load_count", 32'(load_count), 32'(exp_ldc));
            chk("store_count", 32'(store_count), 32'(exp_stc));
`endif
        end
    end

    function automatic logic [4:0] ctl(input int sz, input bit en, input bit wr, input bit se);
        return {2'(sz), en, wr, se};
    endfunction

    task automatic op(input bit c, input logic [4:0] ctrl, input int a, input logic [31:0] d);
        clr      = c;
        mem_ctrl = ctrl;
        addr     = 9'(a);
        data_in  = d;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    localparam int B = 0, H = 1, W = 2, R = 3;

    initial begin
        op(1, 5'h0, 0, 0);
        op(1, 5'h0, 0, 0);
        chk("reset data_out", data_out, 32'h0);
        chk("reset sticky", 32'(fault_sticky), 32'h0);

        // Fill the RAM so every later load reads defined bytes.
        for (int i = 0; i < 128; i++) op(0, ctl(W, 1, 1, 0), i * 4, $urandom);

        op(0, ctl(W, 1, 1, 0), 8, 32'hDEADBEEF);
        chk("model mem8", 32'(mem_m[8]), 32'hDE);
        chk("model mem11", 32'(mem_m[11]), 32'hEF);
        op(0, ctl(W, 1, 0, 0), 8, 0);
        chk("ldw 8", data_out, 32'hDEADBEEF);
        chk("ldw 8 valid", 32'(load_valid), 32'h1);
        op(0, ctl(B, 1, 0, 1), 9, 0);
        chk("ldb 9 se", data_out, 32'hFFFFFFAD);
        op(0, ctl(B, 1, 0, 0), 9, 0);
        chk("ldb 9 ze", data_out, 32'h000000AD);
        op(0, ctl(H, 1, 0, 1), 10, 0);
        chk("ldh 10 se", data_out, 32'hFFFFBEEF);
        op(0, ctl(B, 1, 1, 0), 11, 32'h12);
        op(0, ctl(W, 1, 0, 0), 8, 0);
        chk("ldw after stb", data_out, 32'hDEADBE12);
        op(0, ctl(W, 1, 0, 0), 6, 0);
        chk("misal hold", data_out, 32'hDEADBE12);
        chk("misal lv", 32'(load_valid), 32'h0);
        chk("misal pulse", 32'(misaligned), 32'h1);
        chk("misal sticky", 32'(fault_sticky), 32'h1);
        op(0, ctl(B, 0, 0, 0), 0, 0);
        chk("misal drop", 32'(misaligned), 32'h0);
        chk("sticky holds", 32'(fault_sticky), 32'h1);
        op(0, ctl(R, 1, 0, 0), 0, 0);
        chk("size11 pulse", 32'(misaligned), 32'h1);
        chk("size11 hold", data_out, 32'hDEADBE12);
        op(1, ctl(W, 1, 1, 0), 8, 32'h11111111);
        chk("clr data", data_out, 32'h0);
        chk("clr sticky", 32'(fault_sticky), 32'h0);
        op(0, ctl(W, 1, 0, 0), 8, 0);
        chk("no write in clr", data_out, 32'hDEADBE12);

`ifdef DATA_MEM_STATS_EN
        op(1, 5'h0, 0, 0);
        op(0, ctl(W, 1, 1, 0), 16, 32'h01020304);
        op(0, ctl(H, 1, 1, 0), 20, 32'h0506);
        op(0, ctl(B, 1, 1, 0), 23, 32'h07);
        op(0, ctl(W, 1, 0, 0), 16, 0);
        op(0, ctl(H, 1, 0, 0), 20, 0);
        op(0, ctl(W, 1, 0, 0), 22, 0);
        chk("store_count 3", 32'(store_count), 32'd3);
        chk("load_count 2", 32'(load_count), 32'd2);
        op(1, 5'h0, 0, 0);
        chk("store_count clr", 32'(store_count), 32'd0);
        chk("load_count clr", 32'(load_count), 32'd0);
`endif

        // Randomized traffic, mostly aligned, with occasional faults and clr.
        for (int i = 0; i < 3000; i++) begin
            int sz, a;
            bit c;
            sz = ($urandom_range(0, 15) == 0) ? R : int'($urandom_range(0, 2));
            a  = int'($urandom_range(0, 511));
            if (sz != R && $urandom_range(0, 7) != 0) a = a & ~((1 << sz) - 1);
            c  = ($urandom_range(0, 63) == 0);
            op(c, ctl(sz, $urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1))), a, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
